// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI SRAM transaction sequencer.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StIssue,
    StSettle,
    StWait,
    StHold,
    StGap
  } state_e;

  localparam int unsigned CntW = 4;

  localparam logic [7:0] CmdReadDefault  = 8'h03;
  localparam logic [7:0] CmdWriteDefault = 8'h02;

endpackage

// File: rtl/spi_mem_ctrl.sv
// Turns a single-byte CPU read/write into a chip-selected SPI SRAM frame
// (opcode, address MSB-first, data/dummy) fed byte by byte to the SPI byte engine.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [7:0]  CMD_READ  = CmdReadDefault,
  parameter logic [7:0]  CMD_WRITE = CmdWriteDefault,
  parameter int unsigned CS_SETUP  = 1,
  parameter int unsigned CS_HOLD   = 1,
  parameter int unsigned CS_GAP    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o,
  output logic              ack_o,
  output logic              busy_o,
  output logic              spi_cs_n_o,
  output logic [7:0]        eng_data_tx_o,
  output logic              eng_txn_start_o,
  input  logic              eng_txn_done_i,
  input  logic [7:0]        eng_data_rx_i
);

  localparam int unsigned NAddr   = ADDR_W / 8;
  localparam int unsigned LastIdx = NAddr + 1;

  if ((ADDR_W == 0) || (ADDR_W % 8 != 0) || (LastIdx > 15) ||
      (CS_SETUP < 1) || (CS_SETUP > 15) || (CS_HOLD < 1) || (CS_HOLD > 15) ||
      (CS_GAP < 1) || (CS_GAP > 15)) begin : g_bad_param
    $error("spi_mem_ctrl: parameter out of range");
  end

  localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(CS_GAP - 1);
  localparam logic [CntW-1:0] IdxLast   = CntW'(LastIdx);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              cs_n_q, cs_n_d;
  logic [7:0]        data_tx_q, data_tx_d;
  logic [7:0]        tx_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      data_tx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      cs_n_q    <= cs_n_d;
      data_tx_q <= data_tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    busy_d    = busy_q;
    cs_n_d    = cs_n_q;
    data_tx_d = data_tx_q;
    tx_byte   = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (req_i && eng_txn_done_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          state_d = StIssue;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StIssue:  state_d = StSettle;
      // Engine's done flag only drops the cycle after start, so skip one look.
      StSettle: state_d = StWait;
      StWait: begin
        if (eng_txn_done_i) begin
          if (idx_q < IdxLast) begin
            idx_d   = idx_q + 4'd1;
            state_d = StIssue;
          end else begin
            if (!we_q) rdata_d = eng_data_rx_i;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          ack_d   = 1'b1;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame byte for the index about to be issued; loaded only on entry to ISSUE.
    if (idx_d == '0) begin
      tx_byte = we_q ? CMD_WRITE : CMD_READ;
    end else if (idx_d == IdxLast) begin
      tx_byte = we_q ? wdata_q : 8'h00;
    end else begin
      for (int unsigned i = 1; i <= NAddr; i++) begin
        if (idx_d == CntW'(i)) tx_byte = addr_q[ADDR_W - 8*i +: 8];
      end
    end
    if ((state_d == StIssue) && (state_q != StIssue)) data_tx_d = tx_byte;
  end

  assign rdata_o         = rdata_q;
  assign ack_o           = ack_q;
  assign busy_o          = busy_q;
  assign spi_cs_n_o      = cs_n_q;
  assign eng_data_tx_o   = data_tx_q;
  assign eng_txn_start_o = (state_q == StIssue);

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
Transaction sequencer sitting directly upstream of the SPI byte engine (spi_core). It turns a single CPU-side memory request (read or write one byte) into a complete SPI SRAM command frame: it drives chip-select, then feeds the byte engine the command, address and data bytes one at a time and captures the read byte. The block owns spi_cs_n; the byte engine owns SCK and MOSI.

Parameters:
ADDR_W, 16, CPU address width; must be a multiple of 8; sent MSB-first as ADDR_W/8 bytes.
CMD_READ, 8'h03, SPI read opcode.
CMD_WRITE, 8'h02, SPI write opcode.
CS_SETUP, 1, clk cycles from cs_n falling to the first txn_start (range 1..15).
CS_HOLD, 1, clk cycles from the last byte done to cs_n rising (range 1..15).
CS_GAP, 2, minimum clk cycles cs_n stays high between frames (range 1..15).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
req  in  1  CPU request; held high until ack
we  in  1  1 = write, 0 = read; sampled with req
addr  in  ADDR_W  byte address; sampled with req
wdata  in  8  write data; sampled with req
rdata  out  8  read data; valid on ack, held until the next read completes
ack  out  1  one-cycle completion pulse
busy  out  1  high from acceptance to the end of CS_GAP
spi_cs_n  out  1  SPI chip select, active-low
eng_data_tx  out  8  byte to the engine
eng_txn_start  out  1  one-cycle start pulse to the engine
eng_txn_done  in  1  engine idle (high when no byte is in flight)
eng_data_rx  in  8  last byte received by the engine

Behaviour:
- Reset values: rdata=0, ack=0, busy=0, spi_cs_n=1, eng_data_tx=0, eng_txn_start=0. Counters are cleared and the FSM enters IDLE.
- Reset mid-frame: on the next edge, spi_cs_n=1 and no start pulse. The frame is abandoned with no ack. The engine shares rst_n.
- FSM states: IDLE, SETUP, ISSUE, SETTLE, WAIT, HOLD, GAP.
- IDLE: if req=1 and eng_txn_done=1, latch we/addr/wdata, set byte index=0, set busy=1, drive spi_cs_n=0, go to SETUP.
- SETUP: count CS_SETUP cycles, then go to ISSUE.
- ISSUE: for one cycle, eng_txn_start=1 and eng_data_tx = frame byte[idx]. Then go to SETTLE.
  - Frame bytes: idx0 = opcode (CMD_WRITE if we, else CMD_READ).
  - idx1..N: address bytes, MSB first (N = ADDR_W/8).
  - idx N+1: wdata on a write, 8'h00 dummy on a read.
- SETTLE: one cycle, done is ignored. The engine's done flag does not drop until the cycle after start. Go to WAIT.
- WAIT: hold until eng_txn_done=1.
  - If idx < N+1: idx++ and go to ISSUE. This gives no extra gap cycle and cs_n stays low.
  - Otherwise: on a read, capture eng_data_rx into rdata; then go to HOLD.
- HOLD: count CS_HOLD cycles, then drive spi_cs_n=1, pulse ack for one cycle, go to GAP.
- GAP: count CS_GAP cycles with cs_n high, then clear busy and go to IDLE.
- Handshake: req is not sampled outside IDLE. A req held high through ack starts a new frame only after GAP ends. On a write, rdata is unchanged.
- Invariants:
  - eng_txn_start is never asserted while eng_txn_done=0 or spi_cs_n=1.
  - Exactly N+2 start pulses per frame.
- eng_data_tx keeps its value outside ISSUE.
- All counters are 4 bits and saturate-free. Parameter ranges are checked by an elaboration assertion.
- Frame latency, req accepted to ack: CS_SETUP + (N+2)·(2+Tb) + CS_HOLD + 1 cycles. Tb is the engine's busy time per byte.

Decomposition:
- Package spi_mem_pkg holds the FSM state enum, the default opcodes and the counter width constant.
- No sub-module. The byte engine is a sibling instantiated alongside this block by the parent, not inside it.

Test Plan:
- Read, addr=16'h1234, SRAM model byte=8'hA5 → MOSI bytes 03,12,34,00 in one cs_n-low window; rdata=A5; ack high exactly 1 cycle.
- Write, addr=16'hBEEF, wdata=8'h5A → MOSI bytes 02,BE,EF,5A; then a read of BEEF returns 5A and rdata keeps 5A until the next read.
- req held high across two reads → cs_n high for ≥CS_GAP=2 cycles between frames; busy stays high through GAP.
- rst_n low during the second address byte → spi_cs_n=1 and start=0 on the next edge, no ack; a read after release of addr=16'h0001 succeeds.
- Engine divider=31 (slow) → exactly 4 start pulses per frame; no start ever while eng_txn_done=0; latency matches the formula.
- addr=16'hFFFF read → address bytes FF,FF sent unchanged; no wrap or carry into the opcode.
